// File: rtl/masked_logic_hpc3_pkg.sv
// Shared definitions for the HPC3 masked logic block.
// Contents: operation mode encodings and the helpers that size and index
// the per-bit randomness.
package masked_logic_hpc3_pkg;

    localparam int unsigned MODE_AND  = 0;
    localparam int unsigned MODE_NAND = 1;
    localparam int unsigned MODE_OR   = 2;
    localparam int unsigned MODE_NOR  = 3;
    localparam int unsigned MODE_XOR  = 4;
    localparam int unsigned MODE_XNOR = 5;

    // Number of unordered share pairs for masking order d.
    function automatic int unsigned half_rnd(input int unsigned d);
        return (d * (d + 1)) / 2;
    endfunction

    // Row-major index of share pair (i, j), i < j, out of n shares.
    function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j,
                                             input int unsigned n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/masked_logic_hpc3_bit_core.sv
// hpc3_bit_core: one masked AND bit using the HPC3 gadget.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : capture enable (partial-product registers hold when low)
//   a, b     : operand shares (share s at index s)
//   r        : randomness, low half r_ij, high half r'_ij, pairs row-major
//   c        : output shares, compressed combinationally from the registers
module hpc3_bit_core
    import masked_logic_hpc3_pkg::*;
#(
    parameter int unsigned shares = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [shares-1:0]                    a,
    input  logic [shares-1:0]                    b,
    input  logic [2*half_rnd(shares-1)-1:0]      r,
    output logic [shares-1:0]                    c
);

    localparam int unsigned hr = half_rnd(shares - 1);

    // r_ij and r'_ij are symmetric, so map (i, j) and (j, i) to the same slot.
    function automatic int unsigned pidx(input int unsigned i, input int unsigned j);
        if (i < j) begin
            return pair_idx(i, j, shares);
        end
        return pair_idx(j, i, shares);
    endfunction

    logic [shares-1:0] p_d, p_q;
    logic [shares-1:0] u_d [shares];
    logic [shares-1:0] u_q [shares];
    logic [shares-1:0] v_d [shares];
    logic [shares-1:0] v_q [shares];

    // Every nonlinear term gets its own register; diagonal entries stay zero.
    always_comb begin
        for (int unsigned i = 0; i < shares; i++) begin
            p_d[i] = a[i] & b[i];
            u_d[i] = '0;
            v_d[i] = '0;
            for (int unsigned j = 0; j < shares; j++) begin
                if (j != i) begin
                    u_d[i][j] = (a[i] & (b[j] ^ r[pidx(i, j)])) ^ r[hr + pidx(i, j)];
                    v_d[i][j] = (~a[i] & r[pidx(i, j)]) ^ r[hr + pidx(i, j)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            u_q <= '{default: '0};
            v_q <= '{default: '0};
        end else if (en) begin
            p_q <= p_d;
            u_q <= u_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < shares; i++) begin
            c[i] = p_q[i] ^ (^(u_q[i] ^ v_q[i]));
        end
    end

endmodule

// File: rtl/masked_logic_hpc3.sv
// masked_logic_hpc3: width parallel masked bits, one-cycle latency.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : a, b and r valid this cycle
//   a, b      : operands, bit k share s at index k*(d+1)+s
//   r         : randomness, bit k uses [k*rnd_per_bit +: rnd_per_bit]
//   out_valid : c valid
//   c         : masked result, same packing as a
module masked_logic_hpc3
    import masked_logic_hpc3_pkg::*;
#(
    parameter int unsigned security_order = 1,
    parameter int unsigned width          = 8,
    parameter int unsigned mode           = 0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    input  logic [width*(security_order+1)-1:0]           a,
    input  logic [width*(security_order+1)-1:0]           b,
    input  logic [width*2*half_rnd(security_order)-1:0]   r,
    output logic                                          out_valid,
    output logic [width*(security_order+1)-1:0]           c
);

    localparam int unsigned shares      = security_order + 1;
    localparam int unsigned rnd_per_bit = 2 * half_rnd(security_order);
    localparam logic inv_in  = (mode == MODE_OR) || (mode == MODE_NOR);
    localparam logic inv_out = (mode == MODE_NAND) || (mode == MODE_OR) ||
                               (mode == MODE_XNOR);
    localparam logic is_xor  = (mode == MODE_XOR) || (mode == MODE_XNOR);

    if (mode > MODE_XNOR) begin : gen_bad_mode
        $error("masked_logic_hpc3: illegal mode %0d", mode);
    end
    if (security_order < 1) begin : gen_bad_order
        $error("masked_logic_hpc3: security_order must be at least 1");
    end

    logic                      valid_q;
    logic                      inv_q;
    logic [width*shares-1:0]   c_core;

    // The share-0 output inversion is itself registered, so c reads as all
    // zero straight out of reset and holds across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                inv_q <= inv_out;
            end
        end
    end

    assign out_valid = valid_q;

    if (is_xor) begin : gen_xor
        logic [width*shares-1:0] x_q;
        logic                    unused_r;

        assign unused_r = ^r;

        // Linear: share-wise XOR needs no randomness.
        always_ff @(posedge clk) begin
            if (rst) begin
                x_q <= '0;
            end else if (in_valid) begin
                x_q <= a ^ b;
            end
        end
        assign c_core = x_q;
    end else begin : gen_and
        for (genvar k = 0; k < width; k++) begin : gen_bit
            logic [shares-1:0] a_k, b_k;

            // De Morgan: invert share 0 of each operand to turn AND into OR.
            assign a_k = a[k*shares +: shares] ^ shares'(inv_in);
            assign b_k = b[k*shares +: shares] ^ shares'(inv_in);

            hpc3_bit_core #(
                .shares (shares)
            ) u_core (
                .clk (clk),
                .rst (rst),
                .en  (in_valid),
                .a   (a_k),
                .b   (b_k),
                .r   (r[k*rnd_per_bit +: rnd_per_bit]),
                .c   (c_core[k*shares +: shares])
            );
        end
    end

    always_comb begin
        c = c_core;
        for (int unsigned k = 0; k < width; k++) begin
            c[k*shares] = c_core[k*shares] ^ inv_q;
        end
    end

endmodule

// File: tb/tb_masked_logic_hpc3.sv
module tb_masked_logic_hpc3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] a1, b1, r1;
    logic [23:0] a2, b2;
    logic [47:0] r2;

    logic [15:0] c1  [6];
    logic        ov1 [6];
    logic [23:0] c2;
    logic        ov2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // d=1, width=8, one instance per mode
    for (genvar m = 0; m < 6; m++) begin : gen_dut
        masked_logic_hpc3 #(
            .security_order (1),
            .width          (8),
            .mode           (m)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .a         (a1),
            .b         (b1),
            .r         (r1),
            .out_valid (ov1[m]),
            .c         (c1[m])
        );
    end

    // d=2, width=8, OR
    masked_logic_hpc3 #(
        .security_order (2),
        .width          (8),
        .mode           (2)
    ) u_or2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a2),
        .b         (b2),
        .r         (r2),
        .out_valid (ov2),
        .c         (c2)
    );

    function automatic logic [7:0] unmask1(input logic [15:0] v);
        logic [7:0] u;
        for (int k = 0; k < 8; k++) u[k] = v[2*k] ^ v[2*k+1];
        return u;
    endfunction

    function automatic logic [7:0] unmask2(input logic [23:0] v);
        logic [7:0] u;
        for (int k = 0; k < 8; k++) u[k] = v[3*k] ^ v[3*k+1] ^ v[3*k+2];
        return u;
    endfunction

    function automatic logic [7:0] ref_fn(input int m, input logic [7:0] x, input logic [7:0] y);
        case (m)
            0:       return x & y;
            1:       return ~(x & y);
            2:       return x | y;
            3:       return ~(x | y);
            4:       return x ^ y;
            default: return ~(x ^ y);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        a1 = 16'($urandom);
        b1 = 16'($urandom);
        r1 = 16'($urandom);
        a2 = 24'($urandom);
        b2 = 24'($urandom);
        r2 = {16'($urandom), $urandom};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        randomize_inputs();
        step();
        step();
        for (int m = 0; m < 6; m++) begin
            checks++;
            if (ov1[m] !== 1'b0 || c1[m] !== 16'h0000) begin
                errors++;
                $display("FAIL reset mode%0d: ov=%b c=%h, need ov=0 c=0000", m, ov1[m], c1[m]);
            end
        end
        checks++;
        if (ov2 !== 1'b0 || c2 !== 24'h0) begin
            errors++;
            $display("FAIL reset or_d2: ov=%b c=%h, need ov=0 c=000000", ov2, c2);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_and_vector();
        // Bit 0: a shares (1,0) and b shares (0,1) both unmask to 1, r01=r'01=1.
        a1 = 16'h0001;
        b1 = 16'h0002;
        r1 = 16'h0003;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (ov1[0] !== 1'b1) begin
            errors++;
            $display("FAIL and_vec_valid: ov=%b, need 1", ov1[0]);
        end
        checks++;
        if (c1[0] !== 16'h0002) begin
            errors++;
            $display("FAIL and_vec_shares: c=%h, need 0002", c1[0]);
        end
        checks++;
        if (unmask1(c1[1]) !== 8'hFE) begin
            errors++;
            $display("FAIL nand_vec_unmasked: c=%h, need fe", unmask1(c1[1]));
        end
    endtask

    task automatic test_share_combos();
        logic [3:0] n;
        for (int i = 0; i < 16; i++) begin
            n = 4'(i);
            a1 = {8{n[1:0]}};
            b1 = {8{n[3:2]}};
            r1 = 16'($urandom);
            in_valid = 1'b1;
            step();
            for (int m = 0; m < 6; m++) begin
                checks++;
                if (unmask1(c1[m]) !== ref_fn(m, unmask1(a1), unmask1(b1))) begin
                    errors++;
                    $display("FAIL combo%0d mode%0d: got %h, need %h", i, m,
                             unmask1(c1[m]), ref_fn(m, unmask1(a1), unmask1(b1)));
                end
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            randomize_inputs();
            step();
            checks++;
            if (ov2 !== 1'b1 || unmask2(c2) !== (unmask2(a2) | unmask2(b2))) begin
                errors++;
                $display("FAIL b2b_or_d2 vec%0d: ov=%b c=%h, need ov=1 c=%h", i, ov2,
                         unmask2(c2), unmask2(a2) | unmask2(b2));
            end
            for (int m = 0; m < 6; m++) begin
                checks++;
                if (ov1[m] !== 1'b1 ||
                    unmask1(c1[m]) !== ref_fn(m, unmask1(a1), unmask1(b1))) begin
                    errors++;
                    $display("FAIL b2b_mode%0d vec%0d: ov=%b c=%h, need ov=1 c=%h", m, i,
                             ov1[m], unmask1(c1[m]), ref_fn(m, unmask1(a1), unmask1(b1)));
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_valid_gap();
        step();
        checks++;
        if (ov1[4] !== 1'b0) begin
            errors++;
            $display("FAIL gap_idle: ov=%b, need 0", ov1[4]);
        end
        a1 = 16'h1234;
        b1 = 16'h00FF;
        r1 = 16'($urandom);
        in_valid = 1'b1;
        step();
        checks++;
        if (ov1[4] !== 1'b1 || c1[4] !== 16'h12CB || c1[5] !== 16'h479E) begin
            errors++;
            $display("FAIL gap_first: ov=%b xor=%h xnor=%h, need ov=1 12cb 479e",
                     ov1[4], c1[4], c1[5]);
        end
        in_valid = 1'b0;
        a1 = 16'hBEEF;
        b1 = 16'h7777;
        step();
        checks++;
        if (ov1[4] !== 1'b0 || c1[4] !== 16'h12CB || c1[5] !== 16'h479E) begin
            errors++;
            $display("FAIL gap_hold: ov=%b xor=%h xnor=%h, need ov=0 12cb 479e",
                     ov1[4], c1[4], c1[5]);
        end
        a1 = 16'hFFFF;
        b1 = 16'h0F0F;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (ov1[4] !== 1'b1 || c1[4] !== 16'hF0F0 || c1[5] !== 16'hA5A5) begin
            errors++;
            $display("FAIL gap_second: ov=%b xor=%h xnor=%h, need ov=1 f0f0 a5a5",
                     ov1[4], c1[4], c1[5]);
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1;
        randomize_inputs();
        step();
        randomize_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int m = 0; m < 6; m++) begin
                checks++;
                if (ov1[m] !== 1'b0 || c1[m] !== 16'h0000) begin
                    errors++;
                    $display("FAIL midrst%0d mode%0d: ov=%b c=%h, need ov=0 c=0000", pass, m,
                             ov1[m], c1[m]);
                end
            end
            checks++;
            if (ov2 !== 1'b0 || c2 !== 24'h0) begin
                errors++;
                $display("FAIL midrst%0d or_d2: ov=%b c=%h, need ov=0 c=000000", pass, ov2, c2);
            end
            step();
        end
        in_valid = 1'b1;
        randomize_inputs();
        step();
        in_valid = 1'b0;
        for (int m = 0; m < 6; m++) begin
            checks++;
            if (ov1[m] !== 1'b1 || unmask1(c1[m]) !== ref_fn(m, unmask1(a1), unmask1(b1))) begin
                errors++;
                $display("FAIL post_rst mode%0d: ov=%b c=%h, need ov=1 c=%h", m, ov1[m],
                         unmask1(c1[m]), ref_fn(m, unmask1(a1), unmask1(b1)));
            end
        end
    endtask

    task automatic test_randomness();
        logic [15:0] c_r0 [6];
        a1 = 16'h9C3A;
        b1 = 16'h5E71;
        r1 = 16'h0000;
        in_valid = 1'b1;
        step();
        for (int m = 0; m < 6; m++) c_r0[m] = c1[m];
        // Flip every r_ij, keep r'_ij: each gadget share flips, unmasked value does not.
        r1 = 16'h5555;
        step();
        in_valid = 1'b0;
        for (int m = 0; m < 6; m++) begin
            checks++;
            if (unmask1(c1[m]) !== unmask1(c_r0[m]) ||
                unmask1(c1[m]) !== ref_fn(m, unmask1(a1), unmask1(b1))) begin
                errors++;
                $display("FAIL rnd_unmasked mode%0d: got %h/%h, need %h", m, unmask1(c_r0[m]),
                         unmask1(c1[m]), ref_fn(m, unmask1(a1), unmask1(b1)));
            end
            checks++;
            if ((c1[m] ^ c_r0[m]) !== ((m < 4) ? 16'hFFFF : 16'h0000)) begin
                errors++;
                $display("FAIL rnd_shares mode%0d: diff=%h, need %h", m, c1[m] ^ c_r0[m],
                         (m < 4) ? 16'hFFFF : 16'h0000);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a1 = '0;
        b1 = '0;
        r1 = '0;
        a2 = '0;
        b2 = '0;
        r2 = '0;
        test_reset();
        test_and_vector();
        test_share_combos();
        test_back_to_back();
        test_valid_gap();
        test_reset_midstream();
        test_randomness();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
